// File: rtl/limitcounter_cascade.sv
// rtl/limitcounter_cascade.sv - cascadable modulo-N digit counter with preset and carry
// Optional LIMITCOUNTER_DOWN_EN adds a down port for borrow-style down counting.
module limitcounter_cascade #(
    parameter int WIDTH = 4
) (
    input  logic             clk_control,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             en,
`ifdef LIMITCOUNTER_DOWN_EN
    input  logic             down,
`endif
    input  logic [WIDTH-1:0] period,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             terminal
);

    logic             clk_in_d;
    logic             tick;
    logic [WIDTH-1:0] last;

    // period==0 wraps to all ones, giving the full 2^WIDTH modulus
    assign last = period - 1'b1;
    assign tick = clk_in & ~clk_in_d & en;

`ifdef LIMITCOUNTER_DOWN_EN
    assign terminal = down ? (count == '0) : (count == last);
`else
    assign terminal = (count == last);
`endif

    always_ff @(posedge clk_control) begin
        if (reset) begin
            count     <= '0;
            carry_out <= 1'b0;
            // history starts high so a tick line held high through reset is not an edge
            clk_in_d  <= 1'b1;
        end else begin
            clk_in_d <= clk_in;
            if (load) begin
                count     <= (load_value <= last) ? load_value : '0;
                carry_out <= 1'b0;
            end else if (tick) begin
`ifdef LIMITCOUNTER_DOWN_EN
                if (down) begin
                    if (count == '0) begin
                        count     <= last;
                        carry_out <= 1'b1;
                    end else if (count > last) begin
                        count     <= last;
                        carry_out <= 1'b0;
                    end else begin
                        count     <= count - 1'b1;
                        carry_out <= 1'b0;
                    end
                end else
`endif
                // >= also catches a count stranded above a freshly shrunk period
                if (count >= last) begin
                    count     <= '0;
                    carry_out <= 1'b1;
                end else begin
                    count     <= count + 1'b1;
                    carry_out <= 1'b0;
                end
            end else begin
                carry_out <= 1'b0;
            end
        end
    end

endmodule
